// File: rtl/sva_range_impl_checker.sv
// Checker for `a ##[MIN_DLY:MAX_DLY] b |-> c` (overlapping implication).
// One slot per attempt age; the oldest slot retires into saturating outcome counters.
module sva_range_impl_checker #(
  parameter int unsigned MIN_DLY = 1,
  parameter int unsigned MAX_DLY = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             fail_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] vac_cnt
);

  // Bit j set when age j lies inside the delay window.
  localparam logic [MAX_DLY:1] WinMask = {MAX_DLY{1'b1}} << (MIN_DLY - 1);

  logic [MAX_DLY:1] valid_q, valid_d;
  logic [MAX_DLY:1] match_q, match_d;
  logic [MAX_DLY:1] viol_q, viol_d;
  logic [MAX_DLY:1] eval_b, viol_set, match_upd, viol_upd;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] pass_q, pass_d, failc_q, failc_d, vac_q, vac_d;
  logic             ret_valid, ret_match, ret_viol;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == {CNT_W{1'b1}}) ? x : x + 1'b1;
  endfunction

  // Invalid slots are masked before b/c are looked at.
  always_comb begin
    eval_b    = valid_q & WinMask & {MAX_DLY{b}};
    viol_set  = eval_b & {MAX_DLY{~c}};
    match_upd = match_q | (eval_b & {MAX_DLY{c}});
    viol_upd  = viol_q | viol_set;
    fail_d    = |viol_set;
  end

  generate
    if (MAX_DLY > 1) begin : g_shift
      assign valid_d = {valid_q[MAX_DLY-1:1], a & en};
      assign match_d = {match_upd[MAX_DLY-1:1], 1'b0};
      assign viol_d  = {viol_upd[MAX_DLY-1:1], 1'b0};
    end else begin : g_single
      assign valid_d = a & en;
      assign match_d = 1'b0;
      assign viol_d  = 1'b0;
    end
  endgenerate

  assign ret_valid = valid_q[MAX_DLY];
  assign ret_match = match_upd[MAX_DLY];
  assign ret_viol  = viol_upd[MAX_DLY];

  always_comb begin
    pass_d  = pass_q;
    failc_d = failc_q;
    vac_d   = vac_q;
    if (clr) begin
      pass_d  = '0;
      failc_d = '0;
      vac_d   = '0;
    end else if (ret_valid) begin
      if (ret_viol) begin
        failc_d = sat_inc(failc_q);
      end else if (ret_match) begin
        pass_d = sat_inc(pass_q);
      end else begin
        vac_d = sat_inc(vac_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      match_q <= '0;
      viol_q  <= '0;
      fail_q  <= 1'b0;
      pass_q  <= '0;
      failc_q <= '0;
      vac_q   <= '0;
    end else begin
      valid_q <= valid_d;
      match_q <= match_d;
      viol_q  <= viol_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      failc_q <= failc_d;
      vac_q   <= vac_d;
    end
  end

  assign fail_o   = fail_q;
  assign busy_o   = |valid_q;
  assign pass_cnt = pass_q;
  assign fail_cnt = failc_q;
  assign vac_cnt  = vac_q;

endmodule

// File: tb/tb_sva_range_impl_checker.sv
// Scoreboard bench: an attempt-list model predicts every cycle's outputs for a
// 16-bit-counter instance and a 2-bit-counter instance sharing the same stimulus.
module tb_sva_range_impl_checker;

  localparam int MIN = 1;
  localparam int MAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, clr = 1'b0, a = 1'b0, b = 1'b0, c = 1'b0;
  logic fail_w, busy_w, fail_s, busy_s;
  logic [15:0] p16, f16, v16;
  logic [1:0] p2, f2, v2;

  sva_range_impl_checker #(.MIN_DLY(MIN), .MAX_DLY(MAX), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b), .c(c),
    .fail_o(fail_w), .busy_o(busy_w), .pass_cnt(p16), .fail_cnt(f16), .vac_cnt(v16)
  );

  sva_range_impl_checker #(.MIN_DLY(MIN), .MAX_DLY(MAX), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b), .c(c),
    .fail_o(fail_s), .busy_o(busy_s), .pass_cnt(p2), .fail_cnt(f2), .vac_cnt(v2)
  );

  always #5 clk = ~clk;

  typedef struct {int s; bit m; bit v;} att_t;
  typedef struct packed {
    logic fail; logic busy;
    logic [15:0] p, f, v;
    logic [1:0] ps, fs, vs;
  } exp_t;

  att_t att_q[$];
  exp_t sb_q[$];
  int t = 0;
  int mp = 0, mf = 0, mv = 0, mps = 0, mfs = 0, mvs = 0;
  bit mfail = 0;
  int n_pass = 0, n_tot = 0;

  function automatic int sat(int x, int mx);
    return (x < mx) ? x + 1 : x;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Attempt list: each entry remembers the edge its `a` was sampled on.
  task automatic model_edge();
    att_t nq[$];
    bit viol;
    exp_t e;
    t++;
    if (rst) begin
      att_q.delete();
      mp = 0; mf = 0; mv = 0; mps = 0; mfs = 0; mvs = 0;
      mfail = 0;
    end else begin
      viol = 0;
      foreach (att_q[i]) begin
        att_t x;
        int age;
        x = att_q[i];
        age = t - x.s;
        if (age >= MIN && age <= MAX && b) begin
          if (c) x.m = 1;
          else begin x.v = 1; viol = 1; end
        end
        if (age == MAX) begin
          if (!clr) begin
            if (x.v) begin mf = sat(mf, 65535); mfs = sat(mfs, 3); end
            else if (x.m) begin mp = sat(mp, 65535); mps = sat(mps, 3); end
            else begin mv = sat(mv, 65535); mvs = sat(mvs, 3); end
          end
        end else begin
          nq.push_back(x);
        end
      end
      att_q = nq;
      if (clr) begin mp = 0; mf = 0; mv = 0; mps = 0; mfs = 0; mvs = 0; end
      if (a && en) att_q.push_back('{t, 1'b0, 1'b0});
      mfail = viol;
    end
    e.fail = mfail;
    e.busy = (att_q.size() > 0);
    e.p = 16'(mp); e.f = 16'(mf); e.v = 16'(mv);
    e.ps = 2'(mps); e.fs = 2'(mfs); e.vs = 2'(mvs);
    sb_q.push_back(e);
  endtask

  task automatic step(bit ia, bit ib, bit ic, bit ien, bit iclr, bit irst);
    a = ia; b = ib; c = ic; en = ien; clr = iclr; rst = irst;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 1, 0, 0);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("fail_o", 32'(fail_w), 32'(e.fail));
      chk("busy_o", 32'(busy_w), 32'(e.busy));
      chk("pass_cnt", 32'(p16), 32'(e.p));
      chk("fail_cnt", 32'(f16), 32'(e.f));
      chk("vac_cnt", 32'(v16), 32'(e.v));
      chk("w2_fail_o", 32'(fail_s), 32'(e.fail));
      chk("w2_busy_o", 32'(busy_s), 32'(e.busy));
      chk("w2_pass_cnt", 32'(p2), 32'(e.ps));
      chk("w2_fail_cnt", 32'(f2), 32'(e.fs));
      chk("w2_vac_cnt", 32'(v2), 32'(e.vs));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    // Violation at age 2 with c low.
    step(0, 0, 0, 1, 0, 1);
    chk("rst_busy", 32'(busy_w), 0);
    chk("rst_fail_cnt", 32'(f16), 0);
    step(1, 0, 0, 1, 0, 0);
    idle(1);
    step(0, 1, 0, 1, 0, 0);
    chk("t1_fail_pulse", 32'(fail_w), 1);
    idle(1);
    chk("t1_fail_clear", 32'(fail_w), 0);
    chk("t1_fail_cnt", 32'(f16), 1);
    chk("t1_pass_cnt", 32'(p16), 0);
    chk("t1_vac_cnt", 32'(v16), 0);
    // Match at age 2.
    step(0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0, 0);
    idle(1);
    step(0, 1, 1, 1, 0, 0);
    chk("t2_no_fail", 32'(fail_w), 0);
    idle(1);
    chk("t2_pass_cnt", 32'(p16), 1);
    // b at age 4 and at age 0 are both outside the window.
    step(0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0, 0);
    idle(3);
    step(0, 1, 0, 1, 0, 0);
    chk("t3_no_fail", 32'(fail_w), 0);
    chk("t3_vac_cnt", 32'(v16), 1);
    step(1, 1, 0, 1, 0, 0);
    idle(3);
    chk("t3_vac_age0", 32'(v16), 2);
    chk("t3_fail_cnt", 32'(f16), 0);
    // Three overlapping attempts violate on one edge.
    step(0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    chk("t4_pulse", 32'(fail_w), 1);
    idle(1);
    chk("t4_single_pulse", 32'(fail_w), 0);
    idle(1);
    chk("t4_fail_cnt", 32'(f16), 3);
    // Match then violation within one attempt.
    step(0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    idle(1);
    step(0, 1, 0, 1, 0, 0);
    chk("t5_fail_cnt", 32'(f16), 1);
    chk("t5_pass_cnt", 32'(p16), 0);
    // Reset discards in-flight attempt.
    step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    chk("t6_rst_busy", 32'(busy_w), 0);
    idle(3);
    chk("t6_rst_fail_cnt", 32'(f16), 0);
    chk("t6_rst_vac_cnt", 32'(v16), 0);
    // Four failing attempts; the 2-bit counter saturates at 3.
    repeat (4) step(1, 1, 0, 1, 0, 0);
    repeat (3) step(0, 1, 0, 1, 0, 0);
    chk("t6_sat16", 32'(f16), 4);
    chk("t6_sat2", 32'(f2), 3);
    step(0, 0, 0, 1, 1, 0);
    chk("t6_clr16", 32'(f16), 0);
    chk("t6_clr2", 32'(f2), 0);
    // Randomised traffic.
    repeat (3000) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 199) == 0));
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
